// File: rtl/radio_const_pkg.sv
// Constants shared by the radio datapath filters: coefficient format,
// accumulator width and the interpolator prototype coefficient sets.
package radio_const_pkg;

  localparam int COEF_W          = 32;
  localparam int ACC_W           = 64;
  localparam int QUANT_FRAC_BITS = 10;

  typedef logic signed [COEF_W-1:0] coef_t;

  // 4-tap prototype for 2x interpolation; Q.10, i.e. 1.0, 2.0, 3.0, 4.0.
  localparam coef_t INTERP2_COEFFS [4] = '{
    32'sd1024, 32'sd2048, 32'sd3072, 32'sd4096
  };

endpackage

// File: rtl/fir_interp_mac.sv
// Signed multiply feeding a 64-bit accumulator with synchronous clear/enable.
// sum_o exposes acc + a*b so a caller can capture the final sum in the same cycle.
module fir_interp_mac
  import radio_const_pkg::*;
#(
  parameter int A_W = 16,
  parameter int B_W = COEF_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr_i,
  input  logic                    en_i,
  input  logic signed [A_W-1:0]   a_i,
  input  logic signed [B_W-1:0]   b_i,
  output logic signed [ACC_W-1:0] sum_o
);

  localparam int PROD_W = A_W + B_W;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  acc_d;

  always_comb begin
    prod  = PROD_W'(a_i) * PROD_W'(b_i);
    sum_o = acc_q + ACC_W'(prod);
  end

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = sum_o;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/fir_interp.sv
// Polyphase interpolating FIR: one input sample in, INTERP outputs out, one in
// phase order, using a single sequential MAC over the TPP taps of each phase.
module fir_interp
  import radio_const_pkg::*;
#(
  parameter int    INTERP             = 2,
  parameter int    FIFO_DATA_WIDTH    = 16,
  parameter int    NUM_TAPS           = 32,
  parameter int    FRAC_BITS          = QUANT_FRAC_BITS,
  parameter coef_t COEFFS [NUM_TAPS]  = '{default: '0}
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rd_fifo_empty,
  output logic                       rd_fifo_rd_en,
  input  logic [FIFO_DATA_WIDTH-1:0] rd_fifo_data_in,
  input  logic                       wr_fifo_full,
  output logic                       wr_fifo_wr_en,
  output logic [FIFO_DATA_WIDTH-1:0] wr_fifo_data_out
);

  localparam int DW    = FIFO_DATA_WIDTH;
  localparam int TPP   = NUM_TAPS / INTERP;
  localparam int TAP_W = (TPP > 1) ? $clog2(TPP) : 1;
  localparam int PH_W  = (INTERP > 1) ? $clog2(INTERP) : 1;
  localparam int IDX_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;

  typedef enum logic [1:0] {IDLE, MAC, WRITE} state_e;

  state_e                state_q, state_d;
  logic signed [DW-1:0]  hist_q [TPP];
  logic signed [DW-1:0]  hist_d [TPP];
  logic [TAP_W-1:0]      tap_q, tap_d;
  logic [PH_W-1:0]       phase_q, phase_d;
  logic [DW-1:0]         dout_q, dout_d;

  logic                  rd_en, wr_en;
  logic                  mac_clr, mac_en;
  logic                  tap_last, phase_last;
  logic [IDX_W-1:0]      coef_idx;
  logic signed [DW-1:0]  hist_cur;
  coef_t                 coef_cur;
  logic signed [ACC_W-1:0] mac_sum;

  // Arithmetic shift back to sample scale, then keep the low bits (wraps, no clamp).
  function automatic logic [DW-1:0] dequant(input logic signed [ACC_W-1:0] v);
    return DW'(v >>> FRAC_BITS);
  endfunction

  assign tap_last   = (tap_q == TAP_W'(TPP - 1));
  assign phase_last = (phase_q == PH_W'(INTERP - 1));

  always_comb begin
    coef_idx = IDX_W'(int'(tap_q) * INTERP + int'(phase_q));
    coef_cur = COEFFS[coef_idx];
    hist_cur = hist_q[tap_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!rd_fifo_empty) state_d = MAC;
      MAC:     if (tap_last) state_d = WRITE;
      WRITE:   if (!wr_fifo_full) state_d = phase_last ? IDLE : MAC;
      default: state_d = IDLE;
    endcase
  end

  // FIFO strobes are gated by rst so nothing moves during a reset cycle.
  always_comb begin
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    mac_en  = 1'b0;
    mac_clr = 1'b1;
    if (!rst) begin
      case (state_q)
        IDLE:  rd_en = !rd_fifo_empty;
        MAC: begin
          mac_en  = 1'b1;
          mac_clr = 1'b0;
        end
        WRITE: wr_en = !wr_fifo_full;
        default: ;
      endcase
    end
  end

  assign rd_fifo_rd_en    = rd_en;
  assign wr_fifo_wr_en    = wr_en;
  assign wr_fifo_data_out = dout_q;

  fir_interp_mac #(
    .A_W (DW),
    .B_W (COEF_W)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .clr_i (mac_clr),
    .en_i  (mac_en),
    .a_i   (hist_cur),
    .b_i   (coef_cur),
    .sum_o (mac_sum)
  );

  always_comb begin
    hist_d  = hist_q;
    tap_d   = tap_q;
    phase_d = phase_q;
    dout_d  = dout_q;
    case (state_q)
      IDLE: begin
        if (rd_en) begin
          for (int j = TPP - 1; j > 0; j--) begin
            hist_d[j] = hist_q[j-1];
          end
          hist_d[0] = signed'(rd_fifo_data_in);
          tap_d     = '0;
          phase_d   = '0;
        end
      end
      MAC: begin
        tap_d = tap_q + 1'b1;
        if (tap_last) begin
          tap_d  = '0;
          dout_d = dequant(mac_sum);
        end
      end
      WRITE: begin
        if (wr_en && !phase_last) begin
          phase_d = phase_q + 1'b1;
          tap_d   = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < TPP; j++) begin
        hist_q[j] <= '0;
      end
      tap_q   <= '0;
      phase_q <= '0;
      dout_q  <= '0;
    end else begin
      hist_q  <= hist_d;
      tap_q   <= tap_d;
      phase_q <= phase_d;
      dout_q  <= dout_d;
    end
  end

endmodule

// File: tb/tb_fir_interp.sv
// Scoreboard bench for fir_interp (INTERP=2, 4 taps): a FIFO model feeds the DUT,
// a sum-of-products reference fills the expected queue, a monitor checks pushes.
module tb_fir_interp;

  localparam int INTERP = 2;
  localparam int NTAPS  = 4;
  localparam int TPP    = NTAPS / INTERP;
  localparam int FRAC   = 10;
  localparam int DW     = 16;
  localparam longint MODEL_COEF [NTAPS] = '{1024, 2048, 3072, 4096};

  logic          clk;
  logic          rst;
  logic          rd_fifo_empty;
  logic          rd_fifo_rd_en;
  logic [DW-1:0] rd_fifo_data_in;
  logic          wr_fifo_full;
  logic          wr_fifo_wr_en;
  logic [DW-1:0] wr_fifo_data_out;

  fir_interp #(
    .INTERP          (INTERP),
    .FIFO_DATA_WIDTH (DW),
    .NUM_TAPS        (NTAPS),
    .FRAC_BITS       (FRAC),
    .COEFFS          (radio_const_pkg::INTERP2_COEFFS)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .rd_fifo_empty    (rd_fifo_empty),
    .rd_fifo_rd_en    (rd_fifo_rd_en),
    .rd_fifo_data_in  (rd_fifo_data_in),
    .wr_fifo_full     (wr_fifo_full),
    .wr_fifo_wr_en    (wr_fifo_wr_en),
    .wr_fifo_data_out (wr_fifo_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] in_q  [$];
  logic [DW-1:0] exp_q [$];
  longint        hist_m [TPP];
  int            rd_times [$];
  int            wr_times [$];
  int            n_checks, n_fail, tcount, starve;
  bit            rand_starve, rand_full, force_full;
  bit            rd_s, wr_s, rst_s;

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  // Reference: each consumed sample enters the history, then every phase
  // p yields sum_j hist[j]*h[j*INTERP+p], scaled down by 2^FRAC and wrapped.
  task automatic consume();
    logic signed [DW-1:0] s;
    longint acc;
    s = signed'(in_q.pop_front());
    for (int j = TPP - 1; j > 0; j--) hist_m[j] = hist_m[j-1];
    hist_m[0] = longint'(s);
    for (int p = 0; p < INTERP; p++) begin
      acc = 0;
      for (int j = 0; j < TPP; j++) acc += hist_m[j] * MODEL_COEF[j*INTERP + p];
      exp_q.push_back(DW'(acc >>> FRAC));
    end
  endtask

  task automatic refresh();
    rd_fifo_empty   = (in_q.size() == 0) || (starve > 0) ||
                      (rand_starve && ($urandom_range(0, 3) == 0));
    rd_fifo_data_in = (in_q.size() > 0) ? in_q[0] : '0;
    wr_fifo_full    = force_full || (rand_full && ($urandom_range(0, 2) == 0));
  endtask

  task automatic tick();
    @(negedge clk);
    rd_s  = (rd_fifo_rd_en === 1'b1);
    wr_s  = (wr_fifo_wr_en === 1'b1);
    rst_s = rst;
    if (rd_s) rd_times.push_back(tcount);
    if (wr_s) wr_times.push_back(tcount);
    @(posedge clk);
    #1;
    tcount++;
    if (rd_s && !rst_s && in_q.size() > 0) consume();
    if (starve > 0) starve--;
    refresh();
  endtask

  task automatic load(input logic [DW-1:0] v);
    in_q.push_back(v);
    refresh();
  endtask

  task automatic wait_rd(input string name);
    int k = 0;
    do begin
      tick();
      k++;
    end while (!rd_s && k < 100);
    check({name, "_rd_seen"}, longint'(rd_s), 1);
  endtask

  task automatic drain(input string name, input int limit);
    int k = 0;
    while ((in_q.size() > 0 || exp_q.size() > 0) && k < limit) begin
      tick();
      k++;
    end
    repeat (4) tick();
    check({name, "_drained"}, longint'(in_q.size() + exp_q.size()), 0);
  endtask

  task automatic monitor();
    logic [DW-1:0] e;
    forever begin
      @(negedge clk);
      if (wr_fifo_wr_en === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_push: got %h required no push", wr_fifo_data_out);
        end else begin
          e = exp_q.pop_front();
          if (wr_fifo_data_out !== e) begin
            n_fail++;
            $display("FAIL out_sample: got %h required %h", wr_fifo_data_out, e);
          end
        end
      end
    end
  endtask

  task automatic watchdog();
    #500000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  endtask

  initial begin
    logic [DW-1:0] held;
    int wr_cnt, rd_cnt;
    n_checks = 0; n_fail = 0; tcount = 0; starve = 0;
    rand_starve = 0; rand_full = 0; force_full = 0;
    for (int j = 0; j < TPP; j++) hist_m[j] = 0;
    rst = 1'b1;
    refresh();
    fork
      monitor();
      watchdog();
    join_none

    repeat (3) begin
      tick();
      check("rst_rd_en", longint'(rd_s), 0);
      check("rst_wr_en", longint'(wr_s), 0);
    end
    check("rst_data_out", longint'(wr_fifo_data_out), 0);
    rst = 1'b0;
    refresh();

    // impulse and first-push latency
    rd_times.delete(); wr_times.delete();
    load(16'd1); load(16'd0); load(16'd0);
    drain("impulse", 200);
    check("impulse_latency", longint'(wr_times[0] - rd_times[0]), TPP + 1);
    check("impulse_push_count", longint'(wr_times.size()), 6);

    // scaled and negative input
    load(16'd5); load(16'hFFFF); load(16'd0);
    drain("negative", 200);

    // throughput with a never-empty input FIFO
    rd_times.delete(); wr_times.delete();
    for (int i = 0; i < 10; i++) load(DW'($urandom));
    drain("throughput", 400);
    for (int i = 1; i < rd_times.size(); i++)
      check("rd_spacing", longint'(rd_times[i] - rd_times[i-1]), 1 + INTERP * (TPP + 1));
    check("push_per_pop", longint'(wr_times.size()), longint'(INTERP * rd_times.size()));

    // backpressure held for 10 cycles in WRITE
    load(DW'($urandom)); load(DW'($urandom));
    wait_rd("bp");
    force_full = 1'b1;
    refresh();
    tick(); tick();
    held = wr_fifo_data_out;
    check("bp_held_value", longint'(held), longint'(exp_q[0]));
    repeat (10) begin
      tick();
      check("bp_wr_en", longint'(wr_s), 0);
      check("bp_rd_en", longint'(rd_s), 0);
      check("bp_data_stable", longint'(wr_fifo_data_out), longint'(held));
    end
    force_full = 1'b0;
    refresh();
    tick();
    check("bp_resume_push", longint'(wr_s), 1);
    drain("bp", 200);

    // input starvation for 20 cycles after a read
    load(DW'($urandom)); load(DW'($urandom)); load(DW'($urandom));
    wait_rd("starve");
    starve = 20;
    refresh();
    wr_cnt = 0; rd_cnt = 0;
    repeat (20) begin
      tick();
      wr_cnt += int'(wr_s);
      rd_cnt += int'(rd_s);
    end
    check("starve_pending_pushes", longint'(wr_cnt), INTERP);
    check("starve_no_reads", longint'(rd_cnt), 0);
    drain("starve", 300);

    // reset during the MAC of phase 1
    load(16'd1);
    wait_rd("rst_mid");
    load(16'd1); load(16'd0);
    tick(); tick(); tick();
    rst = 1'b1;
    repeat (2) begin
      tick();
      check("rst_mid_wr_en", longint'(wr_s), 0);
      check("rst_mid_rd_en", longint'(rd_s), 0);
    end
    rst = 1'b0;
    check("rst_mid_data_out", longint'(wr_fifo_data_out), 0);
    check("rst_mid_discarded", longint'(exp_q.size()), 1);
    exp_q.delete();
    for (int j = 0; j < TPP; j++) hist_m[j] = 0;
    refresh();
    drain("rst_mid", 200);

    // random stimulus with random empty and full flags
    rand_starve = 1'b1;
    rand_full   = 1'b1;
    for (int i = 0; i < 30; i++) load(DW'($urandom));
    drain("random", 3000);
    rand_starve = 1'b0;
    rand_full   = 1'b0;
    refresh();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
